zombie_motion_scheduler: RTL and testbench

Time-multiplexed motion controller for up to NUM_SLOTS walking sprites (zombies). One shared subtract/compare datapath is sequenced across all slots, one slot per Clk cycle, after each qualifying frame tick. The block allocates slots on spawn requests, frees them on kill requests or when a sprite reaches the house edge, and exposes a read port so the renderer and collision logic can fetch any slot's state.

---
 rtl/zombie_pkg.sv | 24 ++
 rtl/zombie_slot_alloc.sv | 24 ++
 rtl/zombie_motion_scheduler.sv | 169 ++++++++++++++++
 tb/tb_zombie_motion_scheduler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/zombie_pkg.sv
// rtl/zombie_pkg.sv - shared types and constants for the zombie motion scheduler
package zombie_pkg;

    localparam int LANE_COUNT   = 5;
    localparam int SCREEN_X_MAX = 639;

    typedef struct packed {
        logic       active;
        logic [9:0] x;
        logic [2:0] row;
    } slot_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } sched_state_t;

    // Lanes above the last one are pinned to the last lane
    function automatic logic [2:0] clamp_row(input logic [2:0] row);
        return (row > 3'(LANE_COUNT - 1)) ? 3'(LANE_COUNT - 1) : row;
    endfunction

endpackage

// File: rtl/zombie_slot_alloc.sv
// rtl/zombie_slot_alloc.sv - lowest-index free slot priority encoder
module zombie_slot_alloc #(
    parameter int NUM_SLOTS = 8
) (
    input  logic [NUM_SLOTS-1:0]         active_i,
    output logic                         valid_o,
    output logic [$clog2(NUM_SLOTS)-1:0] idx_o
);

    localparam int IDX_W = $clog2(NUM_SLOTS);

    // Walk downward so the lowest free index is the last one written
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!active_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/zombie_motion_scheduler.sv
// rtl/zombie_motion_scheduler.sv - time-multiplexed sprite motion scheduler
module zombie_motion_scheduler
    import zombie_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int X_SPAWN   = 639,
    parameter int X_MIN     = 0,
    parameter int X_STEP    = 1,
    parameter int FRAME_DIV = 2
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         frame_tick,
    input  logic                         spawn_req,
    input  logic [2:0]                   spawn_row,
    output logic                         spawn_ack,
    output logic [$clog2(NUM_SLOTS)-1:0] spawn_idx,
    input  logic                         kill_req,
    input  logic [$clog2(NUM_SLOTS)-1:0] kill_idx,
    input  logic [$clog2(NUM_SLOTS)-1:0] rd_idx,
    output logic [9:0]                   rd_x,
    output logic [2:0]                   rd_row,
    output logic                         rd_active,
    output logic                         busy,
    output logic                         house_hit,
    output logic                         overrun,
    output logic [4:0]                   active_count
);

    localparam int IDX_W = $clog2(NUM_SLOTS);

    sched_state_t     state_q, state_d;
    logic [3:0]       div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
    logic             overrun_q, overrun_d;

    slot_t            slots_q [NUM_SLOTS];
    slot_t            slots_d [NUM_SLOTS];
    logic             house_hit_q, house_hit_d;
    logic             spawn_ack_q, spawn_ack_d;
    logic [IDX_W-1:0] spawn_idx_q, spawn_idx_d;
    logic [4:0]       count_q, count_d;
    logic [9:0]       rd_x_q;
    logic [2:0]       rd_row_q;
    logic             rd_active_q;

    logic [NUM_SLOTS-1:0] slot_active;
    logic                 alloc_valid;
    logic [IDX_W-1:0]     alloc_idx;
    logic                 spawn_go;
    logic                 kill_hit;
    logic                 scan_kill;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_active
        assign slot_active[g] = slots_q[g].active;
    end

    zombie_slot_alloc #(.NUM_SLOTS(NUM_SLOTS)) u_alloc (
        .active_i (slot_active),
        .valid_o  (alloc_valid),
        .idx_o    (alloc_idx)
    );

    assign spawn_go  = (state_q == ST_IDLE) && !frame_tick && spawn_req && alloc_valid;
    assign kill_hit  = kill_req && slots_q[kill_idx].active;
    assign scan_kill = kill_req && (kill_idx == scan_idx_q);

    // Frame divider and scan sequencing; a tick mid-scan only flags overrun
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        scan_idx_d = scan_idx_q;
        overrun_d  = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    if (div_cnt_q == 4'(FRAME_DIV - 1)) begin
                        div_cnt_d  = '0;
                        scan_idx_d = '0;
                        state_d    = ST_SCAN;
                    end else begin
                        div_cnt_d = div_cnt_q + 4'd1;
                    end
                end
            end
            ST_SCAN: begin
                if (frame_tick) begin
                    overrun_d = 1'b1;
                end
                if (scan_idx_q == IDX_W'(NUM_SLOTS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Slot table update: kill first, then the shared step/compare, then spawn
    always_comb begin
        slots_d     = slots_q;
        house_hit_d = 1'b0;
        spawn_ack_d = 1'b0;
        spawn_idx_d = spawn_idx_q;
        if (kill_req) begin
            slots_d[kill_idx] = '0;
        end
        if ((state_q == ST_SCAN) && !scan_kill && slots_q[scan_idx_q].active) begin
            if ({1'b0, slots_q[scan_idx_q].x} <= 11'(X_MIN + X_STEP)) begin
                slots_d[scan_idx_q] = '0;
                house_hit_d         = 1'b1;
            end else begin
                slots_d[scan_idx_q].x = slots_q[scan_idx_q].x - 10'(X_STEP);
            end
        end
        if (spawn_go) begin
            slots_d[alloc_idx] = '{active: 1'b1, x: 10'(X_SPAWN), row: clamp_row(spawn_row)};
            spawn_ack_d        = 1'b1;
            spawn_idx_d        = alloc_idx;
        end
        count_d = count_q + 5'(spawn_go) - 5'(kill_hit) - 5'(house_hit_d);
    end

    // State registers; read port samples the table before this edge's update
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            div_cnt_q   <= '0;
            scan_idx_q  <= '0;
            overrun_q   <= 1'b0;
            house_hit_q <= 1'b0;
            spawn_ack_q <= 1'b0;
            spawn_idx_q <= '0;
            count_q     <= '0;
            rd_x_q      <= '0;
            rd_row_q    <= '0;
            rd_active_q <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            scan_idx_q  <= scan_idx_d;
            overrun_q   <= overrun_d;
            house_hit_q <= house_hit_d;
            spawn_ack_q <= spawn_ack_d;
            spawn_idx_q <= spawn_idx_d;
            count_q     <= count_d;
            rd_x_q      <= slots_q[rd_idx].x;
            rd_row_q    <= slots_q[rd_idx].row;
            rd_active_q <= slots_q[rd_idx].active;
            slots_q     <= slots_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign spawn_ack    = spawn_ack_q;
    assign spawn_idx    = spawn_idx_q;
    assign house_hit    = house_hit_q;
    assign overrun      = overrun_q;
    assign active_count = count_q;
    assign rd_x         = rd_x_q;
    assign rd_row       = rd_row_q;
    assign rd_active    = rd_active_q;

endmodule

// File: tb/tb_zombie_motion_scheduler.sv
// tb/tb_zombie_motion_scheduler.sv - randomized self-checking bench for zombie_motion_scheduler
module tb_zombie_motion_scheduler;

    localparam int NS        = 8;
    localparam int X_SPAWN   = 639;
    localparam int X_MIN     = 0;
    localparam int X_STEP    = 1;
    localparam int FRAME_DIV = 2;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick, spawn_req, kill_req;
    logic [2:0] spawn_row, kill_idx, rd_idx;
    logic       spawn_ack, busy, house_hit, overrun, rd_active;
    logic [2:0] spawn_idx, rd_row;
    logic [9:0] rd_x;
    logic [4:0] active_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: slot table plus scan position (-1 idle, 0..NS-1 scanning, NS done)
    bit m_act [NS];
    int m_x   [NS];
    int m_row [NS];
    int m_pos, m_div, m_sidx;
    bit m_ovr, m_ack, m_hit;
    int e_rx, e_rrow;
    bit e_ract;

    zombie_motion_scheduler dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .spawn_req(spawn_req), .spawn_row(spawn_row),
        .spawn_ack(spawn_ack), .spawn_idx(spawn_idx),
        .kill_req(kill_req), .kill_idx(kill_idx),
        .rd_idx(rd_idx), .rd_x(rd_x), .rd_row(rd_row), .rd_active(rd_active),
        .busy(busy), .house_hit(house_hit), .overrun(overrun),
        .active_count(active_count)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int occupied();
        int n = 0;
        for (int i = 0; i < NS; i++) n += m_act[i];
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_row[i] = 0;
        end
        m_pos = -1; m_div = 0; m_sidx = 0;
        m_ovr = 0; m_ack = 0; m_hit = 0;
        e_rx = 0; e_rrow = 0; e_ract = 0;
    endtask

    task automatic model_step(input bit t, input bit sr, input int row,
                              input bit kr, input int ki, input int ri);
        bit pre_act [NS];
        int next_pos;
        for (int i = 0; i < NS; i++) pre_act[i] = m_act[i];
        e_rx = m_x[ri]; e_rrow = m_row[ri]; e_ract = m_act[ri];
        m_hit = 0; m_ack = 0;
        next_pos = m_pos;
        if (kr) begin
            m_act[ki] = 0; m_x[ki] = 0; m_row[ki] = 0;
        end
        if (m_pos == -1) begin
            if (t) begin
                if (m_div == FRAME_DIV - 1) begin
                    m_div = 0; next_pos = 0;
                end else begin
                    m_div++;
                end
            end else if (sr) begin
                for (int i = 0; i < NS; i++) begin
                    if (!pre_act[i] && !m_ack) begin
                        m_act[i] = 1; m_x[i] = X_SPAWN; m_row[i] = (row > 4) ? 4 : row;
                        m_ack = 1; m_sidx = i;
                    end
                end
            end
        end else if (m_pos < NS) begin
            if (t) m_ovr = 1;
            if (!(kr && ki == m_pos) && m_act[m_pos]) begin
                if (m_x[m_pos] <= X_MIN + X_STEP) begin
                    m_act[m_pos] = 0; m_x[m_pos] = 0; m_row[m_pos] = 0; m_hit = 1;
                end else begin
                    m_x[m_pos] -= X_STEP;
                end
            end
            next_pos = m_pos + 1;
        end else begin
            next_pos = -1;
        end
        m_pos = next_pos;
    endtask

    task automatic compare_all(input string phase);
        check_eq({phase, "_spawn_ack"},    spawn_ack,    m_ack);
        check_eq({phase, "_spawn_idx"},    spawn_idx,    m_sidx);
        check_eq({phase, "_busy"},         busy,         (m_pos != -1));
        check_eq({phase, "_house_hit"},    house_hit,    m_hit);
        check_eq({phase, "_overrun"},      overrun,      m_ovr);
        check_eq({phase, "_active_count"}, active_count, occupied());
        check_eq({phase, "_rd_x"},         rd_x,         e_rx);
        check_eq({phase, "_rd_row"},       rd_row,       e_rrow);
        check_eq({phase, "_rd_active"},    rd_active,    e_ract);
    endtask

    task automatic cycle(input string phase, input bit t, input bit sr, input int row,
                         input bit kr, input int ki, input int ri);
        frame_tick = t; spawn_req = sr; spawn_row = 3'(row);
        kill_req = kr; kill_idx = 3'(ki); rd_idx = 3'(ri);
        model_step(t, sr, row, kr, ki, ri);
        @(posedge Clk);
        #1;
        compare_all(phase);
    endtask

    task automatic do_reset(input string phase);
        Reset = 1'b1;
        frame_tick = $urandom_range(0, 1); spawn_req = $urandom_range(0, 1);
        kill_req = 1'b0; spawn_row = 3'd0; kill_idx = 3'd0; rd_idx = 3'd0;
        @(posedge Clk);
        #1;
        model_reset();
        Reset = 1'b0;
        compare_all(phase);
        check_eq({phase, "_busy_const"},  busy,         0);
        check_eq({phase, "_count_const"}, active_count, 0);
        check_eq({phase, "_ovr_const"},   overrun,      0);
    endtask

    initial begin
        int guard;
        Reset = 1'b0; frame_tick = 1'b0; spawn_req = 1'b0; kill_req = 1'b0;
        spawn_row = 3'd0; kill_idx = 3'd0; rd_idx = 3'd0;
        model_reset();
        @(posedge Clk);
        #1;
        do_reset("rst");

        cycle("dir", 0, 1, 2, 0, 0, 0);
        check_eq("dir_ack_const", spawn_ack, 1);
        check_eq("dir_idx_const", spawn_idx, 0);
        cycle("dir", 0, 0, 0, 0, 0, 0);
        check_eq("dir_rd_x_const",   rd_x,         639);
        check_eq("dir_rd_row_const", rd_row,       2);
        check_eq("dir_count_const",  active_count, 1);

        // Ticks only while idle: sprites walk all the way to the house edge
        for (int n = 0; n < 20000; n++) begin
            cycle("walk", (m_pos == -1) && ($urandom_range(0, 1) == 1),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 7),
                  $urandom_range(0, 1023) == 0, $urandom_range(0, NS - 1),
                  $urandom_range(0, NS - 1));
        end

        // Dense ticks and kills: overruns, kill-vs-scan collisions, refills
        for (int n = 0; n < 2000; n++) begin
            cycle("mix", $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 3) == 0, $urandom_range(0, NS - 1),
                  $urandom_range(0, NS - 1));
        end

        // Reset landing in the middle of a scan
        guard = 0;
        while (!(m_pos >= 1 && m_pos < NS - 1) && guard < 200) begin
            cycle("pre", 1, 0, 0, 0, 0, $urandom_range(0, NS - 1));
            guard++;
        end
        check_eq("scan_reached", (guard < 200), 1);
        do_reset("midscan_rst");
        cycle("post", 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
